// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, entry kinds and opcode classification shared by the ALU result buffer
//   OP_*        4-bit ALU opcodes; 0000 and 1100-1111 are illegal
//   kind_e      FIFO entry kind: KIND_GPR (register-file write) or KIND_HILO (HI/LO retire)
//   op_legal    1 when the opcode produces a result worth queueing
//   op_kind     entry kind for a legal opcode
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_ROL = 4'b1011;

    typedef enum logic {KIND_GPR, KIND_HILO} kind_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op >= OP_ADD && op <= OP_ROL;
    endfunction

    function automatic kind_e op_kind(input logic [3:0] op);
        return (op == OP_DIV || op == OP_MUL) ? KIND_HILO : KIND_GPR;
    endfunction
endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: DEPTH-entry circular FIFO with occupancy count
//   clock, clear_n  rising-edge clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     write wdata at the tail (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   rdata           head entry (undefined while empty)
//   full, empty     occupancy status
//   count           number of stored entries, 0..DEPTH
module alu_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = r_count == (AW+1)'(DEPTH);
    assign empty  = r_count == '0;
    assign count  = r_count;
    assign rdata  = r_mem[r_rp];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Power-of-two DEPTH lets the pointers wrap by plain overflow.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wp] <= wdata;
    end
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: queues ALU results; GPR results go to the register-file port, mul/div to HI/LO
//   clock, clear_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready         result handshake; in_ready depends only on occupancy
//   in_op, in_lo, in_hi       opcode and result words (in_hi used by mul/div only)
//   in_rdest                  destination register index
//   out_valid/out_ready       register-file write handshake with out_data, out_rdest
//   hi_q, lo_q, hilo_we       HI/LO registers and their one-cycle update strobe
//   count                     FIFO occupancy
//   op_err                    sticky illegal-opcode flag
//   ALU_RESULT_FLAGS_EN       adds out_zero, out_neg, hilo_zero status outputs
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int RADDR_W = 4
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic [DATA_W-1:0]      in_lo,
    input  logic [DATA_W-1:0]      in_hi,
    input  logic [RADDR_W-1:0]     in_rdest,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [RADDR_W-1:0]     out_rdest,
    output logic [DATA_W-1:0]      hi_q,
    output logic [DATA_W-1:0]      lo_q,
    output logic                   hilo_we,
`ifdef ALU_RESULT_FLAGS_EN
    output logic                   out_zero,
    output logic                   out_neg,
    output logic                   hilo_zero,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic                   op_err
);
    typedef struct packed {
        kind_e              kind;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
        logic [RADDR_W-1:0] rdest;
    } entry_t;

    entry_t            w_in;
    entry_t            w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_err;

    assign in_ready  = !w_full;
    assign w_accept  = in_valid && in_ready;
    // Illegal opcodes complete the handshake but are dropped.
    assign w_push    = w_accept && op_legal(in_op);
    assign w_in      = '{kind: op_kind(in_op), hi: in_hi, lo: in_lo, rdest: in_rdest};
    assign out_valid = !w_empty && w_head.kind == KIND_GPR;
    // A HILO entry never waits on the register file: it retires the cycle it reaches the head.
    assign hilo_we   = !w_empty && w_head.kind == KIND_HILO;
    assign w_pop     = hilo_we || (out_valid && out_ready);
    assign out_data  = out_valid ? w_head.lo : '0;
    assign out_rdest = out_valid ? w_head.rdest : '0;
    assign hi_q      = r_hi;
    assign lo_q      = r_lo;
    assign op_err    = r_err;

`ifdef ALU_RESULT_FLAGS_EN
    assign out_zero  = out_data == '0;
    assign out_neg   = out_data[DATA_W-1];
    assign hilo_zero = r_hi == '0 && r_lo == '0;
`endif

    alu_result_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clock  (clock),
        .clear_n(clear_n),
        .push   (w_push),
        .wdata  (w_in),
        .pop    (w_pop),
        .rdata  (w_head),
        .full   (w_full),
        .empty  (w_empty),
        .count  (count)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_err <= 1'b0;
        end else begin
            if (hilo_we) begin
                r_hi <= w_head.hi;
                r_lo <= w_head.lo;
            end
            if (w_accept && !op_legal(in_op)) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed and randomized check of alu_result_buffer against a queue model
module tb_alu_result_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int RW    = 4;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [DW-1:0] in_lo = '0;
    logic [DW-1:0] in_hi = '0;
    logic [RW-1:0] in_rdest = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_rdest;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;
    logic          hilo_we;
    logic [1:0]    count;
    logic          op_err;
`ifdef ALU_RESULT_FLAGS_EN
    logic          out_zero;
    logic          out_neg;
    logic          hilo_zero;
`endif

    always #5 clock = ~clock;

    alu_result_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .RADDR_W(RW)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_lo    (in_lo),
        .in_hi    (in_hi),
        .in_rdest (in_rdest),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_rdest(out_rdest),
        .hi_q     (hi_q),
        .lo_q     (lo_q),
        .hilo_we  (hilo_we),
`ifdef ALU_RESULT_FLAGS_EN
        .out_zero (out_zero),
        .out_neg  (out_neg),
        .hilo_zero(hilo_zero),
`endif
        .count    (count),
        .op_err   (op_err)
    );

    typedef struct {
        bit            hilo;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [RW-1:0] rd;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] m_hi;
    logic [DW-1:0] m_lo;
    bit            m_err;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, a, e);
        end
    endtask

    // Reference: a list of pending results; the head retires (HILO) or waits for out_ready (GPR).
    always @(posedge clock or negedge clear_n) begin
        bit   rdy;
        ent_t e;
        if (!clear_n) begin
            q.delete();
            m_hi  = '0;
            m_lo  = '0;
            m_err = 0;
        end else begin
            rdy = q.size() < DEPTH;
            if (q.size() > 0) begin
                if (q[0].hilo) begin
                    m_hi = q[0].hi;
                    m_lo = q[0].lo;
                    void'(q.pop_front());
                end else if (out_ready) begin
                    void'(q.pop_front());
                end
            end
            if (in_valid && rdy) begin
                if (in_op == 4'd0 || in_op >= 4'd12) begin
                    m_err = 1;
                end else begin
                    e.hilo = (in_op == 4'd3 || in_op == 4'd4);
                    e.hi   = in_hi;
                    e.lo   = in_lo;
                    e.rd   = in_rdest;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clock) begin
        bit            e_ov;
        bit            e_we;
        logic [DW-1:0] e_data;
        logic [RW-1:0] e_rd;
        e_ov   = q.size() > 0 && !q[0].hilo;
        e_we   = q.size() > 0 && q[0].hilo;
        e_data = e_ov ? q[0].lo : '0;
        e_rd   = e_ov ? q[0].rd : '0;
        chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("out_data", 64'(out_data), 64'(e_data));
        chk("out_rdest", 64'(out_rdest), 64'(e_rd));
        chk("hilo_we", 64'(hilo_we), 64'(e_we));
        chk("hi_q", 64'(hi_q), 64'(m_hi));
        chk("lo_q", 64'(lo_q), 64'(m_lo));
        chk("count", 64'(count), 64'(q.size()));
        chk("op_err", 64'(op_err), 64'(m_err));
`ifdef ALU_RESULT_FLAGS_EN
        chk("out_zero", 64'(out_zero), 64'(e_data == 0));
        chk("out_neg", 64'(out_neg), 64'(e_data[DW-1]));
        chk("hilo_zero", 64'(hilo_zero), 64'(m_hi == 0 && m_lo == 0));
`endif
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic put(input bit v, input logic [3:0] op, input logic [DW-1:0] hi,
                       input logic [DW-1:0] lo, input logic [RW-1:0] rd);
        in_valid = v;
        in_op    = op;
        in_hi    = hi;
        in_lo    = lo;
        in_rdest = rd;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_hi", 64'(hi_q), 64'd0);
        clear_n = 1'b1;

        out_ready = 1'b1;
        put(1, 4'b0001, 0, 32'h5, 4'd3);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'h5);
        chk("t1_rdest", 64'(out_rdest), 64'd3);
        put(0, 0, 0, 0, 0);
        tick();
        chk("t1_count", 64'(count), 64'd0);

        put(1, 4'b0100, 32'h1, 32'h8000_0000, 0);
        tick();
        chk("t2_we", 64'(hilo_we), 64'd1);
        chk("t2_valid", 64'(out_valid), 64'd0);
        put(0, 0, 0, 0, 0);
        tick();
        chk("t2_hi", 64'(hi_q), 64'h1);
        chk("t2_lo", 64'(lo_q), 64'h8000_0000);

        out_ready = 1'b0;
        put(1, 4'b0101, 0, 32'hA1, 4'd1);
        tick();
        put(1, 4'b0110, 0, 32'hB2, 4'd2);
        tick();
        chk("t3_full_rdy", 64'(in_ready), 64'd0);
        put(1, 4'b0111, 0, 32'hC3, 4'd3);
        tick();
        chk("t3_count", 64'(count), 64'd2);
        chk("t3_hold", 64'(out_data), 64'hA1);
        put(0, 0, 0, 0, 0);
        out_ready = 1'b1;
        tick();
        chk("t3_second", 64'(out_data), 64'hB2);
        chk("t3_second_rd", 64'(out_rdest), 64'd2);
        tick();
        chk("t3_drained", 64'(count), 64'd0);

        out_ready = 1'b0;
        put(1, 4'b0001, 0, 32'h11, 4'd2);
        tick();
        put(1, 4'b0011, 32'h2, 32'h7, 0);
        tick();
        put(0, 0, 0, 0, 0);
        tick();
        chk("t4_blocked_we", 64'(hilo_we), 64'd0);
        chk("t4_hold_hi", 64'(hi_q), 64'h1);
        chk("t4_gpr", 64'(out_data), 64'h11);
        out_ready = 1'b1;
        tick();
        chk("t4_we", 64'(hilo_we), 64'd1);
        tick();
        chk("t4_hi", 64'(hi_q), 64'h2);
        chk("t4_lo", 64'(lo_q), 64'h7);

        chk("t5_err0", 64'(op_err), 64'd0);
        put(1, 4'b0000, 0, 32'h99, 1);
        tick();
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_err", 64'(op_err), 64'd1);
        put(1, 4'b1111, 0, 32'h98, 1);
        tick();
        put(1, 4'b0001, 0, 32'h22, 4);
        tick();
        put(0, 0, 0, 0, 0);
        tick();
        chk("t5_sticky", 64'(op_err), 64'd1);

        out_ready = 1'b0;
        put(1, 4'b0010, 0, 32'h33, 5);
        tick();
        put(1, 4'b1000, 0, 32'h44, 6);
        tick();
        chk("t6_count2", 64'(count), 64'd2);
        out_ready = 1'b1;
        #1 clear_n = 1'b0;
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_hi", 64'(hi_q), 64'd0);
        chk("t6_lo", 64'(lo_q), 64'd0);
        put(0, 0, 0, 0, 0);
        #1 clear_n = 1'b1;
        tick();

        for (int i = 0; i < 3000; i++) begin
            put($urandom_range(3, 0) != 0, 4'($urandom_range(15, 0)), $urandom,
                ($urandom_range(3, 0) == 0) ? 32'h0 : $urandom, 4'($urandom_range(15, 0)));
            out_ready = $urandom_range(2, 0) != 0;
            if (i % 700 == 350) begin
                #1 clear_n = 1'b0;
                #1 clear_n = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
